// File: rtl/cacheline_arbiter.sv
// cacheline_arbiter: shares one burst-memory port between icache line reads and dcache line reads/writebacks.
// Latency: request seen in IDLE -> bmem strobe next cycle; resp pulse 1+BURST_LEN cycles after the request with back-to-back beats.
// Backpressure: beats advance only on bmem_resp; the losing cache stays pending. CACHELINE_ARBITER_RR_EN selects round-robin.
module cacheline_arbiter #(
    parameter int BEAT_W    = 64,
    parameter int BURST_LEN = 4,
    parameter int ADDR_W    = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ADDR_W-1:0]           i_addr,
    input  logic                        i_read,
    output logic [BEAT_W*BURST_LEN-1:0] i_rdata,
    output logic                        i_resp,
    input  logic [ADDR_W-1:0]           d_addr,
    input  logic                        d_read,
    input  logic                        d_write,
    input  logic [BEAT_W*BURST_LEN-1:0] d_wdata,
    output logic [BEAT_W*BURST_LEN-1:0] d_rdata,
    output logic                        d_resp,
    output logic [ADDR_W-1:0]           bmem_address,
    output logic                        bmem_read,
    output logic                        bmem_write,
    input  logic [BEAT_W-1:0]           bmem_rdata,
    output logic [BEAT_W-1:0]           bmem_wdata,
    input  logic                        bmem_resp
);

    localparam int LINE_W = BEAT_W * BURST_LEN;
    localparam int CNT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_t;
    typedef enum logic [1:0] {GNT_NONE, GNT_I, GNT_D} grant_t;

    state_t             state;
    grant_t             grant;
    logic [CNT_W-1:0]   beat;
    logic [ADDR_W-1:0]  addr_q;
    logic [LINE_W-1:0]  line_q;
    logic [LINE_W-1:0]  rd_line;
    logic               i_req;
    logic               d_req;
    logic               pick_d;
    logic               last_beat;
`ifdef CACHELINE_ARBITER_RR_EN
    logic               last_winner_i;
`endif

    always_comb begin
        i_req = i_read;
        d_req = d_read | d_write;
`ifdef CACHELINE_ARBITER_RR_EN
        // On a tie the cache that did not win last time goes first.
        pick_d = d_req & (~i_req | last_winner_i);
`else
        pick_d = d_req;
`endif
    end

    // Line as it will look once the current read beat is merged in.
    always_comb begin
        rd_line = line_q;
        rd_line[int'(beat)*BEAT_W +: BEAT_W] = bmem_rdata;
    end

    assign last_beat    = (beat == LAST_BEAT);
    assign bmem_address = (bmem_read | bmem_write) ? addr_q : '0;
    assign bmem_wdata   = bmem_write ? line_q[int'(beat)*BEAT_W +: BEAT_W] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            grant      <= GNT_NONE;
            beat       <= '0;
            addr_q     <= '0;
            line_q     <= '0;
            i_rdata    <= '0;
            d_rdata    <= '0;
            i_resp     <= 1'b0;
            d_resp     <= 1'b0;
            bmem_read  <= 1'b0;
            bmem_write <= 1'b0;
`ifdef CACHELINE_ARBITER_RR_EN
            last_winner_i <= 1'b1;
`endif
        end else begin
            i_resp <= 1'b0;
            d_resp <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        beat   <= '0;
                        grant  <= pick_d ? GNT_D : GNT_I;
                        addr_q <= pick_d ? d_addr : i_addr;
`ifdef CACHELINE_ARBITER_RR_EN
                        last_winner_i <= ~pick_d;
`endif
                        // A dcache request with write high is a writeback even if read is also high.
                        if (pick_d && d_write) begin
                            line_q     <= d_wdata;
                            bmem_write <= 1'b1;
                            state      <= WR_BURST;
                        end else begin
                            bmem_read <= 1'b1;
                            state     <= RD_BURST;
                        end
                    end
                end
                RD_BURST: begin
                    if (bmem_resp) begin
                        line_q <= rd_line;
                        if (last_beat) begin
                            bmem_read <= 1'b0;
                            state     <= DONE;
                            if (grant == GNT_D) begin
                                d_rdata <= rd_line;
                                d_resp  <= 1'b1;
                            end else begin
                                i_rdata <= rd_line;
                                i_resp  <= 1'b1;
                            end
                        end else begin
                            beat <= beat + CNT_W'(1);
                        end
                    end
                end
                WR_BURST: begin
                    if (bmem_resp) begin
                        if (last_beat) begin
                            bmem_write <= 1'b0;
                            d_resp     <= 1'b1;
                            state      <= DONE;
                        end else begin
                            beat <= beat + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    grant <= GNT_NONE;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Directed plus randomized bench for cacheline_arbiter against a line-granular memory and arbitration model.
module tb_cacheline_arbiter;

    localparam int BEAT_W    = 64;
    localparam int BURST_LEN = 4;
    localparam int ADDR_W    = 32;
    localparam int LINE_W    = BEAT_W * BURST_LEN;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [ADDR_W-1:0] i_addr = '0;
    logic              i_read = 1'b0;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic [ADDR_W-1:0] d_addr = '0;
    logic              d_read = 1'b0;
    logic              d_write = 1'b0;
    logic [LINE_W-1:0] d_wdata = '0;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic [ADDR_W-1:0] bmem_address;
    logic              bmem_read;
    logic              bmem_write;
    logic [BEAT_W-1:0] bmem_rdata;
    logic [BEAT_W-1:0] bmem_wdata;
    logic              bmem_resp;

    cacheline_arbiter #(.BEAT_W(BEAT_W), .BURST_LEN(BURST_LEN), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .bmem_address(bmem_address), .bmem_read(bmem_read), .bmem_write(bmem_write),
        .bmem_rdata(bmem_rdata), .bmem_wdata(bmem_wdata), .bmem_resp(bmem_resp)
    );

    initial forever #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [LINE_W-1:0] mem [logic [31:0]];
    logic [BEAT_W-1:0] wr_q [$];
    int                stall_max  = 0;
    bit                stall_rand = 1'b0;
    bit                stray_en   = 1'b0;
`ifdef CACHELINE_ARBITER_RR_EN
    bit                last_w_d   = 1'b0;
`endif

    task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [LINE_W-1:0] mem_line(input logic [31:0] a);
        logic [LINE_W-1:0] l;
        l = '0;
        if (mem.exists(a)) return mem[a];
        for (int k = 0; k < BURST_LEN; k++) l[k*BEAT_W +: BEAT_W] = {a, 32'(k) ^ 32'hC0DE_0000};
        return l;
    endfunction

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] l;
        l = '0;
        for (int k = 0; k < LINE_W/32; k++) l[k*32 +: 32] = $urandom;
        return l;
    endfunction

    function automatic int next_gap();
        return stall_rand ? int'($urandom_range(0, stall_max)) : stall_max;
    endfunction

    // Burst memory: serves whole lines beat by beat, optionally with idle gaps between beats.
    initial begin : memory
        int                mbeat;
        int                gap;
        int                gap_target;
        bit                active;
        logic [31:0]       burst_addr;
        logic [LINE_W-1:0] mline;
        mbeat = 0; gap = 0; gap_target = 0; active = 1'b0; burst_addr = '0;
        bmem_resp = 1'b0;
        bmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                bmem_resp = 1'b0;
                mbeat = 0; gap = 0; active = 1'b0;
            end else if (bmem_read || bmem_write) begin
                if (!active) begin
                    active = 1'b1;
                    burst_addr = bmem_address;
                    gap = 0;
                    gap_target = next_gap();
                end else begin
                    chk("bmem_address_hold", bmem_address, burst_addr);
                end
                if (gap < gap_target) begin
                    gap++;
                    bmem_resp = 1'b0;
                end else begin
                    gap = 0;
                    gap_target = next_gap();
                    bmem_resp = 1'b1;
                    if (bmem_read) begin
                        mline = mem_line(burst_addr);
                        bmem_rdata = mline[mbeat*BEAT_W +: BEAT_W];
                    end else begin
                        wr_q.push_back(bmem_wdata);
                    end
                    mbeat++;
                    if (mbeat == BURST_LEN) begin
                        mbeat = 0;
                        active = 1'b0;
                    end
                end
            end else begin
                active = 1'b0; mbeat = 0; gap = 0;
                bmem_resp = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
                bmem_rdata = {$urandom, $urandom};
            end
        end
    end

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_i_resp"}, i_resp, 0);
        chk({tag, "_d_resp"}, d_resp, 0);
        chk({tag, "_bmem_read"}, bmem_read, 0);
        chk({tag, "_bmem_write"}, bmem_write, 0);
        chk({tag, "_bmem_address"}, bmem_address, 0);
        chk({tag, "_bmem_wdata"}, bmem_wdata, 0);
        chk({tag, "_i_rdata"}, i_rdata, 0);
        chk({tag, "_d_rdata"}, d_rdata, 0);
    endtask

    // One arbitration round: raise the chosen requests together and serve them to completion.
    task automatic txn(input bit ie, input bit de, input bit dw, input bit rw_both,
                       input logic [31:0] ia, input logic [31:0] da,
                       input logic [LINE_W-1:0] wd, input bit chk_lat);
        logic [LINE_W-1:0] exp_i;
        logic [LINE_W-1:0] exp_d;
        bit pend_i, pend_d, exp_first_d, seen_first, first_d;
        int n, n_first, n_second;
        @(negedge clk);
        exp_i = mem_line(ia);
        exp_d = mem_line(da);
        wr_q.delete();
`ifdef CACHELINE_ARBITER_RR_EN
        exp_first_d = de && (!ie || !last_w_d);
`else
        exp_first_d = de;
`endif
        i_addr = ia; i_read = ie;
        d_addr = da; d_write = de && dw; d_read = de && (!dw || rw_both); d_wdata = wd;
        pend_i = ie; pend_d = de;
        n = 0; n_first = 0; n_second = 0; seen_first = 1'b0; first_d = 1'b0;
        while ((pend_i || pend_d) && n < 300) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) begin
                chk("bmem_strobe_next_cycle", {bmem_read, bmem_write}, (exp_first_d && dw) ? 2'b01 : 2'b10);
                // Only the granted cache's inputs are disturbed; the loser's must stay intact.
                if (exp_first_d) begin
                    d_addr = $urandom;
                    d_wdata = rand_line();
                end else begin
                    i_addr = $urandom;
                end
            end
            if (i_resp || d_resp) begin
                if (!seen_first) begin
                    seen_first = 1'b1;
                    n_first = n;
                    first_d = d_resp;
                end else begin
                    n_second = n;
                end
            end
            if (i_resp) begin
                chk("i_resp_expected", pend_i, 1);
                chk("i_rdata", i_rdata, exp_i);
                pend_i = 1'b0;
                i_read = 1'b0;
            end
            if (d_resp) begin
                chk("d_resp_expected", pend_d, 1);
                if (!dw) chk("d_rdata", d_rdata, exp_d);
                pend_d = 1'b0;
                d_read = 1'b0;
                d_write = 1'b0;
            end
        end
        chk("txn_timeout", pend_i || pend_d, 0);
        if (ie && de) chk("grant_order_d_first", first_d, exp_first_d);
        if (chk_lat) begin
            chk("resp_latency", n_first, 1 + BURST_LEN);
            if (ie && de) chk("second_resp_latency", n_second, 2 * (1 + BURST_LEN) + 1);
        end
        @(posedge clk); #1;
        chk("resp_single_pulse", {i_resp, d_resp}, 2'b00);
        if (de && dw) begin
            chk("wr_beat_count", wr_q.size(), BURST_LEN);
            for (int k = 0; k < BURST_LEN; k++)
                if (k < wr_q.size()) chk("wr_beat", wr_q[k], wd[k*BEAT_W +: BEAT_W]);
            mem[da] = wd;
        end
`ifdef CACHELINE_ARBITER_RR_EN
        last_w_d = (ie && de) ? !exp_first_d : de;
`endif
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [LINE_W-1:0] wb;
        bit ie, de;

        // Reset state
        repeat (3) @(posedge clk);
        #1 chk_outputs_zero("reset");
        @(negedge clk) rst = 1'b1;

        // Icache read alone, back-to-back beats
        mem[32'h6000_0040] = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        txn(1, 0, 0, 0, 32'h6000_0040, 32'h0, '0, 1);
        chk("i_rdata_directed", i_rdata, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                          64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});

        // Dcache writeback, then read the line back through the dcache
        wb = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
              64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        txn(0, 1, 1, 0, 32'h0, 32'h6000_1000, wb, 1);
        txn(0, 1, 0, 0, 32'h0, 32'h6000_1000, '0, 1);
        chk("d_rdata_after_writeback", d_rdata, wb);

        // Simultaneous reads
        txn(1, 1, 0, 0, 32'h6000_0080, 32'h6001_0080, '0, 1);
        txn(1, 1, 0, 0, 32'h6000_00C0, 32'h6001_00C0, '0, 1);

        // Memory stalls of three idle cycles before every beat
        stall_rand = 1'b0; stall_max = 3;
        txn(1, 0, 0, 0, 32'h6000_0100, 32'h0, '0, 0);
        txn(1, 1, 1, 1, 32'h6000_0140, 32'h6001_0140, rand_line(), 0);
        stall_max = 0;

        // Asynchronous reset in the middle of a read burst
        @(negedge clk);
        i_addr = 32'h6000_0180; i_read = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("mid_burst_bmem_read", bmem_read, 1);
        #2 rst = 1'b0;
        #1 chk_outputs_zero("async_reset");
        i_read = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
`ifdef CACHELINE_ARBITER_RR_EN
        last_w_d = 1'b0;
`endif
        repeat (5) begin
            @(posedge clk); #1;
            chk("post_reset_idle", {bmem_read, bmem_write, i_resp, d_resp}, 4'b0000);
        end

        // Stray bmem_resp while idle, then a normal burst
        @(negedge clk) stray_en = 1'b1;
        repeat (8) begin
            @(posedge clk); #1;
            chk("stray_resp_idle", {bmem_read, bmem_write, i_resp, d_resp}, 4'b0000);
        end
        @(negedge clk) stray_en = 1'b0;
        txn(1, 0, 0, 0, 32'h6000_0040, 32'h0, '0, 1);

        // Randomized rounds
        stall_rand = 1'b1;
        for (int r = 0; r < 24; r++) begin
            ie = 1'($urandom_range(0, 1));
            de = ie ? 1'($urandom_range(0, 1)) : 1'b1;
            stall_max = (r % 3 == 0) ? 0 : int'($urandom_range(0, 2));
            txn(ie, de, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                32'h6000_0000 | (32'($urandom_range(0, 15)) << 6),
                32'h6001_0000 | (32'($urandom_range(0, 15)) << 6),
                rand_line(), stall_max == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
